// File: rtl/standlight_pkg.sv
// standlight_pkg: mode codes and duty fractions shared by the stand light controller and indicator logic
package standlight_pkg;
  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_DIM25 = 3'd1;
  localparam logic [2:0] ST_DIM50 = 3'd2;
  localparam logic [2:0] ST_DIM75 = 3'd3;
  localparam logic [2:0] ST_FULL  = 3'd4;
  localparam int DUTY_DEN = 4;
  // Mode codes double as quarter-duty numerators; illegal codes read as dark.
  function automatic int duty_num(input logic [2:0] s);
    return (s <= ST_FULL) ? int'(s) : 0;
  endfunction
endpackage

// File: rtl/pwm_generator.sv
// pwm_generator: free-running PWM whose duty changes only at period boundaries
module pwm_generator #(
  parameter int PWM_PERIOD = 100,
  parameter int DW = $clog2(PWM_PERIOD + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [DW-1:0] i_duty,
  output logic          o_pwm
);
  logic [DW-1:0] pwm_q, duty_q;
  logic          light_q, last;
  assign last  = pwm_q == DW'(PWM_PERIOD - 1);
  assign o_pwm = light_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pwm_q   <= '0;
      duty_q  <= '0;
      light_q <= 1'b0;
    end else begin
      pwm_q   <= last ? '0 : pwm_q + DW'(1);
      duty_q  <= last ? i_duty : duty_q;
      light_q <= pwm_q < duty_q;
    end
  end
endmodule

// File: rtl/standlight_fsm.sv
// standlight_fsm: button-stepped lamp mode controller with optional inactivity auto-off
module standlight_fsm
  import standlight_pkg::*;
#(
  parameter int PWM_PERIOD = 100,
  parameter int AUTO_OFF   = 0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_button,
  output logic       o_light,
  output logic [2:0] o_state
);
  localparam int DW = $clog2(PWM_PERIOD + 1);
  logic [2:0]    state_q, state_d;
  logic [31:0]   idle_q, idle_d;
  logic [DW-1:0] target;
  logic          timeout;
  // A pulse on the timeout cycle wins, so the timeout is masked by i_button.
  assign timeout = (AUTO_OFF != 0) && (state_q != ST_OFF) && !i_button &&
                   (idle_q == 32'(AUTO_OFF - 1));
  always_comb begin
    state_d = (state_q > ST_FULL || timeout) ? ST_OFF :
              i_button ? ((state_q == ST_FULL) ? ST_OFF : state_q + 3'd1) : state_q;
    idle_d  = (AUTO_OFF == 0 || state_q == ST_OFF || i_button || timeout) ? '0 : idle_q + 32'd1;
  end
  assign target  = DW'(duty_num(state_q) * PWM_PERIOD / DUTY_DEN);
  assign o_state = state_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_OFF;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
    end
  end
  pwm_generator #(.PWM_PERIOD(PWM_PERIOD), .DW(DW)) u_pwm (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_duty (target),
    .o_pwm  (o_light)
  );
endmodule

// File: tb/tb_standlight_fsm.sv
// tb_standlight_fsm: directed checks of mode stepping, PWM duty timing, auto-off and async reset
module tb_standlight_fsm;
  logic clk = 1'b0, rst = 1'b1, btn_a = 1'b0, btn_b = 1'b0;
  logic light_a, light_b;
  logic [2:0] st_a, st_b;
  int checks = 0, failures = 0, cyc = 0, h;
  int exp_st [5] = '{1, 2, 3, 4, 0};
  int exp_hi [5] = '{2, 4, 6, 8, 0};
  logic exp_lt [17] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  standlight_fsm #(.PWM_PERIOD(8), .AUTO_OFF(0)) u_a (
    .i_clk(clk), .i_reset(rst), .i_button(btn_a), .o_light(light_a), .o_state(st_a));
  standlight_fsm #(.PWM_PERIOD(8), .AUTO_OFF(20)) u_b (
    .i_clk(clk), .i_reset(rst), .i_button(btn_b), .o_light(light_b), .o_state(st_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic pulse_a();
    btn_a = 1'b1;
    tick(1);
    btn_a = 1'b0;
  endtask

  task automatic pulse_b();
    btn_b = 1'b1;
    tick(1);
    btn_b = 1'b0;
  endtask

  task automatic high_a(output int n);
    n = 0;
    repeat (8) begin
      n += int'(light_a);
      tick(1);
    end
  endtask

  task automatic high_b(output int n);
    n = 0;
    repeat (8) begin
      n += int'(light_b);
      tick(1);
    end
  endtask

  initial begin
    tick(3);
    chk("rst_light", light_a, 0);
    chk("rst_state", st_a, 0);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 24; i++) begin
      chk("off_light_a", light_a, 0);
      chk("off_light_b", light_b, 0);
      tick(1);
    end
    chk("off_state", st_a, 0);
    for (int i = 0; i < 5; i++) begin
      pulse_a();
      chk("step_state", st_a, 32'(exp_st[i]));
      tick(30);
      high_a(h);
      chk("step_high", h, 32'(exp_hi[i]));
    end
    pulse_a();
    chk("dim25_state", st_a, 1);
    tick(20);
    while (cyc % 8 != 0) tick(1);
    for (int i = 0; i < 17; i++) begin
      chk("midperiod_light", light_a, 32'(exp_lt[i]));
      if (i == 3) btn_a = 1'b1;
      tick(1);
      if (i == 3) begin
        btn_a = 1'b0;
        chk("midperiod_state", st_a, 2);
      end
    end
    pulse_b();
    chk("b_dim25", st_b, 1);
    pulse_b();
    chk("b_dim50", st_b, 2);
    tick(19);
    chk("b_before_timeout", st_b, 2);
    tick(1);
    chk("b_auto_off", st_b, 0);
    tick(24);
    high_b(h);
    chk("b_off_high", h, 0);
    pulse_b();
    pulse_b();
    chk("b_rearm", st_b, 2);
    tick(19);
    chk("b_timeout_cycle", st_b, 2);
    btn_b = 1'b1;
    tick(1);
    btn_b = 1'b0;
    chk("b_pulse_wins", st_b, 3);
    tick(19);
    chk("b_restarted", st_b, 3);
    tick(1);
    chk("b_second_off", st_b, 0);
    pulse_a();
    pulse_a();
    chk("a_full", st_a, 4);
    tick(20);
    while (cyc % 8 != 3) tick(1);
    chk("full_light", light_a, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_light", light_a, 0);
    chk("async_state", st_a, 0);
    tick(2);
    rst = 1'b0;
    cyc = 0;
    tick(2);
    pulse_a();
    chk("post_reset_state", st_a, 1);
    tick(20);
    high_a(h);
    chk("post_reset_high", h, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
